// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator for a combinational ALU. Accepts an opcode and two operands,
// steps the ALU through LOAD_Y and EXEC, and returns the captured Z over valid/ready.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready high
// LOAD_Y | Y register loaded from latched operand a
// EXEC   | op/bus driven to the ALU; Z and err captured at end of cycle
// RESP   | result held on resp_* until the consumer accepts it
module alu_sequencer #(
  parameter int REG_SIZE = 32,
  parameter int CNT_SIZE = 16
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [REG_SIZE-1:0] req_a,
  input  logic [REG_SIZE-1:0] req_b,
  output logic [3:0]          alu_ctrl,
  output logic [REG_SIZE-1:0] alu_y,
  output logic [REG_SIZE-1:0] alu_bus,
  input  logic [REG_SIZE-1:0] alu_z,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [REG_SIZE-1:0] resp_data,
  output logic                resp_err,
  output logic [CNT_SIZE-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_Y = 2'd1,
    EXEC   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [3:0]          op_q;
  logic [REG_SIZE-1:0] a_q;
  logic [REG_SIZE-1:0] b_q;
  logic [REG_SIZE-1:0] y_q;
  logic [REG_SIZE-1:0] z_q;
  logic                err_q;
  logic [CNT_SIZE-1:0] cnt_q;
  logic                req_fire;
  logic                resp_fire;
  logic                op_illegal;

  assign req_fire   = req_valid && (state == IDLE);
  assign resp_fire  = resp_ready && (state == RESP);
  // Opcodes 1100..1111 have no ALU function and skip straight to the response.
  assign op_illegal = (req_op[3:2] == 2'b11);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_fire) state_next = op_illegal ? RESP : LOAD_Y;
      LOAD_Y:  state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (req_fire) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
        if (op_illegal) begin
          z_q   <= '0;
          err_q <= 1'b1;
        end
      end
      if (state == LOAD_Y) begin
        y_q <= a_q;
      end
      if (state == EXEC) begin
        z_q   <= alu_z;
        err_q <= 1'b0;
      end
      if (resp_fire) begin
        cnt_q <= cnt_q + CNT_SIZE'(1);
      end
    end
  end

  // ALU control and bus are only non-zero while the ALU is being exercised.
  assign alu_ctrl   = (state == EXEC) ? op_q : 4'b0000;
  assign alu_bus    = (state == EXEC) ? b_q : '0;
  assign alu_y      = y_q;
  assign req_ready  = (state == IDLE) && !clear;
  assign resp_valid = (state == RESP);
  assign resp_data  = z_q;
  assign resp_err   = err_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU is attached to the DUT, and each transaction
// is checked against the operands' expected result, timing and counter value.
module tb_alu_sequencer;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_y;
  logic [31:0] alu_bus;
  logic [31:0] alu_z;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [15:0] op_count;

  // Second instance with a 4-bit counter shares all stimulus; used for wrap checks.
  logic        req_ready4;
  logic [3:0]  alu_ctrl4;
  logic [31:0] alu_y4;
  logic [31:0] alu_bus4;
  logic [31:0] alu_z4;
  logic        resp_valid4;
  logic [31:0] resp_data4;
  logic        resp_err4;
  logic [3:0]  op_count4;

  int passed;
  int total;
  int exp_count;
  int lat;
  logic [31:0] got_data;
  logic        got_err;
  logic        hold_ok;
  logic [3:0]  ctrl_log [0:15];
  logic [31:0] bus_log  [0:15];
  logic [31:0] y_log    [0:15];

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] y,
                                         input logic [31:0] bus);
    case (op)
      4'd0:    return y & bus;
      4'd1:    return y | bus;
      4'd2:    return y + bus;
      4'd3:    return y - bus;
      4'd4:    return y ^ bus;
      4'd5:    return y << bus[4:0];
      4'd6:    return y >> bus[4:0];
      4'd7:    return ~y;
      4'd8:    return bus;
      4'd9:    return y;
      4'd10:   return y * bus;
      4'd11:   return ~(y & bus);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    if (op >= 4'd12) return 32'd0;
    return alu_fn(op, a, b);
  endfunction

  assign alu_z  = alu_fn(alu_ctrl, alu_y, alu_bus);
  assign alu_z4 = alu_fn(alu_ctrl4, alu_y4, alu_bus4);

  alu_sequencer #(.REG_SIZE(32), .CNT_SIZE(16)) u_dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl), .alu_y(alu_y), .alu_bus(alu_bus), .alu_z(alu_z),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .op_count(op_count)
  );

  alu_sequencer #(.REG_SIZE(32), .CNT_SIZE(4)) u_dut4 (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready4),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_ctrl(alu_ctrl4), .alu_y(alu_y4), .alu_bus(alu_bus4), .alu_z(alu_z4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready),
    .resp_data(resp_data4), .resp_err(resp_err4), .op_count(op_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request from an IDLE-aligned point (#1 after an edge), logs ALU-side
  // outputs each cycle, holds off resp_ready for 'hold' cycles, then takes the response.
  task automatic send_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    req_valid  = 1'b1;
    req_op     = op;
    req_a      = a;
    req_b      = b;
    resp_ready = 1'b0;
    @(posedge clock); #1;
    req_op = 4'($urandom);
    req_a  = $urandom;
    req_b  = $urandom;
    lat    = -1;
    for (int k = 1; k < 16; k++) begin
      req_valid   = 1'($urandom);
      ctrl_log[k] = alu_ctrl;
      bus_log[k]  = alu_bus;
      y_log[k]    = alu_y;
      if (resp_valid) begin
        lat = k;
        break;
      end
      @(posedge clock); #1;
    end
    got_data = resp_data;
    got_err  = resp_err;
    hold_ok  = 1'b1;
    if (lat > 0) begin
      for (int h = 0; h < hold; h++) begin
        req_valid = 1'($urandom);
        @(posedge clock); #1;
        if (resp_valid !== 1'b1 || resp_data !== got_data || resp_err !== got_err ||
            req_ready !== 1'b0) hold_ok = 1'b0;
      end
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
      exp_count++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    #3;
    total++;
    if ({alu_ctrl, alu_bus, alu_y, resp_valid, resp_err, resp_data, op_count, req_ready} !== '0)
      $display("FAIL reset_outputs: ctrl=%h bus=%h y=%h rv=%b err=%b data=%h cnt=%0d rr=%b",
               alu_ctrl, alu_bus, alu_y, resp_valid, resp_err, resp_data, op_count, req_ready);
    else passed++;
    @(posedge clock); #1;
    clear = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready);
    else passed++;
    exp_count = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_add();
    send_op(4'b0010, 32'h5, 32'h3, 0);
    total++;
    if (lat !== 3) $display("FAIL add_latency: got %0d want 3", lat); else passed++;
    total++;
    if (got_data !== 32'h8 || got_err !== 1'b0)
      $display("FAIL add_result: got %h err %b want 00000008 err 0", got_data, got_err);
    else passed++;
    total++;
    if (ctrl_log[1] !== 4'd0 || bus_log[1] !== 32'd0)
      $display("FAIL add_load_y_idle_bus: ctrl %h bus %h want 0 0", ctrl_log[1], bus_log[1]);
    else passed++;
    total++;
    if (ctrl_log[2] !== 4'b0010 || bus_log[2] !== 32'h3 || y_log[2] !== 32'h5)
      $display("FAIL add_exec_drive: ctrl %h bus %h y %h want 2 3 5",
               ctrl_log[2], bus_log[2], y_log[2]);
    else passed++;
    total++;
    if (op_count !== 16'(exp_count)) $display("FAIL add_count: got %0d want %0d", op_count, exp_count);
    else passed++;
  endtask

  task automatic test_sub_and();
    send_op(4'b0011, 32'h0, 32'h1, 0);
    total++;
    if (got_data !== 32'hFFFF_FFFF)
      $display("FAIL sub_wrap: got %h want ffffffff", got_data);
    else passed++;
    send_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    total++;
    if (got_data !== 32'hF000_F000) $display("FAIL and_result: got %h want f000f000", got_data);
    else passed++;
    total++;
    if (op_count !== 16'(exp_count)) $display("FAIL sub_and_count: got %0d want %0d", op_count, exp_count);
    else passed++;
  endtask

  task automatic test_illegal();
    logic [31:0] y_before;
    y_before = alu_y;
    send_op(4'b1101, 32'h7, 32'h9, 0);
    total++;
    if (lat !== 1) $display("FAIL illegal_latency: got %0d want 1", lat); else passed++;
    total++;
    if (got_err !== 1'b1 || got_data !== 32'd0)
      $display("FAIL illegal_result: got %h err %b want 00000000 err 1", got_data, got_err);
    else passed++;
    total++;
    if (ctrl_log[1] !== 4'd0 || bus_log[1] !== 32'd0 || alu_y !== y_before)
      $display("FAIL illegal_alu_idle: ctrl %h bus %h y %h want 0 0 %h",
               ctrl_log[1], bus_log[1], alu_y, y_before);
    else passed++;
  endtask

  task automatic test_backpressure();
    send_op(4'b0001, 32'h0F, 32'hF0, 5);
    total++;
    if (got_data !== 32'hFF || lat !== 3)
      $display("FAIL bp_result: got %h lat %0d want 000000ff lat 3", got_data, lat);
    else passed++;
    total++;
    if (hold_ok !== 1'b1) $display("FAIL bp_hold: got %b want 1", hold_ok); else passed++;
    total++;
    if (req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req_ready);
    else passed++;
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          hold;
    for (int i = 0; i < 30; i++) begin
      op   = 4'($urandom_range(0, 15));
      a    = $urandom;
      b    = $urandom;
      hold = $urandom_range(0, 3);
      send_op(op, a, b, hold);
      total++;
      if (lat !== ((op >= 4'd12) ? 1 : 3))
        $display("FAIL rand_latency[%0d]: op %h got %0d", i, op, lat);
      else passed++;
      total++;
      if (got_data !== ref_result(op, a, b) || got_err !== (op >= 4'd12))
        $display("FAIL rand_result[%0d]: op %h got %h err %b want %h err %b", i, op,
                 got_data, got_err, ref_result(op, a, b), (op >= 4'd12));
      else passed++;
      total++;
      if (hold_ok !== 1'b1) $display("FAIL rand_hold[%0d]: got %b want 1", i, hold_ok);
      else passed++;
      total++;
      if (op_count !== 16'(exp_count) || op_count4 !== 4'(exp_count))
        $display("FAIL rand_count[%0d]: got %0d/%0d want %0d", i, op_count, op_count4, exp_count);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    logic [31:0] want;
    logic [3:0]  op;
    int          accepts;
    int          responses;
    accepts   = 0;
    responses = 0;
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op     = 4'($urandom_range(0, 11));
      req_op = op;
      req_a  = $urandom;
      req_b  = $urandom;
      if (req_ready) begin
        accepts++;
        expq.push_back(ref_result(op, req_a, req_b));
      end
      if (resp_valid) begin
        responses++;
        want = (expq.size() > 0) ? expq.pop_front() : 32'hXXXX_XXXX;
        total++;
        if (resp_data !== want) $display("FAIL b2b_data[%0d]: got %h want %h", i, resp_data, want);
        else passed++;
      end
      @(posedge clock); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    exp_count += 4;
    total++;
    if (accepts !== 4 || responses !== 4)
      $display("FAIL b2b_throughput: accepts %0d responses %0d want 4 4", accepts, responses);
    else passed++;
    total++;
    if (op_count !== 16'(exp_count) || req_ready !== 1'b1)
      $display("FAIL b2b_end: count %0d rr %b want %0d 1", op_count, req_ready, exp_count);
    else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic saw_resp;
    req_valid = 1'b1; req_op = 4'b0010; req_a = 32'h1234; req_b = 32'h1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    total++;
    if (alu_ctrl !== 4'b0010) $display("FAIL midop_in_exec: ctrl %h want 2", alu_ctrl);
    else passed++;
    #2 clear = 1'b1;
    #1;
    total++;
    if ({alu_ctrl, alu_bus, alu_y, resp_valid, resp_err, resp_data, op_count, req_ready} !== '0)
      $display("FAIL midop_clear_outputs: ctrl=%h bus=%h y=%h rv=%b err=%b data=%h cnt=%0d rr=%b",
               alu_ctrl, alu_bus, alu_y, resp_valid, resp_err, resp_data, op_count, req_ready);
    else passed++;
    #3 clear = 1'b0;
    exp_count = 0;
    saw_resp  = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (resp_valid) saw_resp = 1'b1;
    end
    resp_ready = 1'b0;
    total++;
    if (saw_resp !== 1'b0 || op_count !== 16'd0 || req_ready !== 1'b1)
      $display("FAIL midop_after: resp %b cnt %0d rr %b want 0 0 1", saw_resp, op_count, req_ready);
    else passed++;
  endtask

  task automatic test_counter_wrap();
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    exp_count = 0;
    @(posedge clock); #1;
    for (int i = 0; i < 16; i++) begin
      send_op(4'($urandom_range(0, 15)), $urandom, $urandom, 0);
      if (i == 14) begin
        total++;
        if (op_count4 !== 4'd15) $display("FAIL wrap_pre: got %0d want 15", op_count4);
        else passed++;
      end
    end
    total++;
    if (op_count4 !== 4'd0 || op_count !== 16'd16)
      $display("FAIL wrap_post: got %0d/%0d want 0/16", op_count4, op_count);
    else passed++;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    exp_count = 0;
    test_reset();
    test_add();
    test_sub_and();
    test_illegal();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
